// File: rtl/t07_esp_pkg.sv
// Shared ESP link definitions: state encoding, word geometry, timer sizing.
package t07_esp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } esp_tx_state_t;

  localparam int ESP_NIBBLES = 8;
  localparam int ESP_WORD_W  = 32;

  // Counter width needed to hold a reload value of (p - 1); never narrower than 1 bit.
  function automatic int esp_timer_w(input int p);
    return $clog2((p > 2) ? p : 2);
  endfunction

endpackage

// File: rtl/t07_esp_hold_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module t07_esp_hold_timer
  import t07_esp_pkg::*;
#(
  parameter int MAX_COUNT = 1,
  parameter int W         = esp_timer_w(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: clear beats load, load beats decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/t07_esp_tx.sv
// ESP nibble-bus transmitter: 32-bit words out as 8 nibbles, MSB first,
// each nibble held HOLD_CYCLES clocks, followed by GAP_CYCLES idle clocks.
module t07_esp_tx
  import t07_esp_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ESP_WORD_W-1:0] word_i,
  input  logic                  wordValid_i,
  output logic                  wordReady_o,
  input  logic                  abort_i,
  output logic [3:0]            ESP_out,
  output logic                  nibbleValid_o,
  output logic                  frameStart_o,
  output logic                  busy_o
);

  localparam int HOLD_W = esp_timer_w(HOLD_CYCLES);
  localparam int GAP_W  = esp_timer_w(GAP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  // A zero gap never loads the gap timer, so its reload value only needs to be legal.
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};
  localparam logic [2:0]        LAST_NIB  = 3'(ESP_NIBBLES - 1);

  esp_tx_state_t         r_state;
  logic [ESP_WORD_W-1:0] r_shift;
  logic [2:0]            r_nib_cnt;

  logic w_accept;
  logic w_hold_tc;
  logic w_gap_tc;
  logic w_last_nib;
  logic w_hold_load;
  logic w_hold_dec;
  logic w_gap_load;
  logic w_gap_dec;

  // Abort always wins over a concurrent valid.
  assign w_accept    = (r_state == IDLE) && wordValid_i && !abort_i;
  assign w_last_nib  = (r_nib_cnt == LAST_NIB);
  assign w_hold_load = w_accept || ((r_state == SEND) && w_hold_tc && !abort_i);
  assign w_hold_dec  = (r_state == SEND) && !w_hold_tc && !abort_i;
  assign w_gap_load  = (GAP_CYCLES > 0) && (r_state == SEND) && w_hold_tc && w_last_nib && !abort_i;
  assign w_gap_dec   = (r_state == GAP) && !w_gap_tc && !abort_i;

  t07_esp_hold_timer #(.MAX_COUNT(HOLD_CYCLES), .W(HOLD_W)) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (abort_i),
    .i_load     (w_hold_load),
    .i_load_val (HOLD_LOAD),
    .i_dec      (w_hold_dec),
    .o_tc       (w_hold_tc)
  );

  t07_esp_hold_timer #(.MAX_COUNT(GAP_CYCLES), .W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (abort_i),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_tc       (w_gap_tc)
  );

  // Transmit FSM with shift register and nibble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= {ESP_WORD_W{1'b0}};
      r_nib_cnt <= 3'd0;
    end else if (abort_i) begin
      r_state   <= IDLE;
      r_shift   <= {ESP_WORD_W{1'b0}};
      r_nib_cnt <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wordValid_i) begin
            r_shift   <= word_i;
            r_nib_cnt <= 3'd0;
            r_state   <= SEND;
          end else begin
            r_state   <= IDLE;
          end
        end
        SEND: begin
          if (w_hold_tc) begin
            r_shift   <= {r_shift[ESP_WORD_W-5:0], 4'h0};
            r_nib_cnt <= r_nib_cnt + 3'd1;
            if (w_last_nib) begin
              r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
              r_state <= SEND;
            end
          end else begin
            r_state <= SEND;
          end
        end
        GAP: begin
          if (w_gap_tc) begin
            r_state <= IDLE;
          end else begin
            r_state <= GAP;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_shift   <= {ESP_WORD_W{1'b0}};
          r_nib_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign wordReady_o   = (r_state == IDLE);
  assign busy_o        = (r_state != IDLE);
  assign nibbleValid_o = (r_state == SEND);
  assign ESP_out       = (r_state == SEND) ? r_shift[ESP_WORD_W-1 -: 4] : 4'h0;
  assign frameStart_o  = (r_state == SEND) && (r_nib_cnt == 3'd0);

endmodule

// File: tb/tb_t07_esp_tx.sv
// Directed bench for t07_esp_tx: one DUT with HOLD=1/GAP=0, one with HOLD=3/GAP=2.
module tb_t07_esp_tx;

  logic        clk;
  logic        rst;

  logic [31:0] a_word, b_word;
  logic        a_valid, b_valid, a_abort, b_abort;
  logic        a_ready, b_ready, a_nv, b_nv, a_fs, b_fs, a_busy, b_busy;
  logic [3:0]  a_esp, b_esp;

  int checks;
  int errors;

  t07_esp_tx u_dut_a (
    .clk(clk), .rst(rst), .word_i(a_word), .wordValid_i(a_valid), .wordReady_o(a_ready),
    .abort_i(a_abort), .ESP_out(a_esp), .nibbleValid_o(a_nv), .frameStart_o(a_fs), .busy_o(a_busy)
  );

  t07_esp_tx #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .word_i(b_word), .wordValid_i(b_valid), .wordReady_o(b_ready),
    .abort_i(b_abort), .ESP_out(b_esp), .nibbleValid_o(b_nv), .frameStart_o(b_fs), .busy_o(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_word = 32'h0; a_valid = 1'b0; a_abort = 1'b0;
    b_word = 32'h0; b_valid = 1'b0; b_abort = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_ready, a_esp, a_nv, a_fs, a_busy} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a got rdy=%b esp=%h nv=%b fs=%b busy=%b exp 1 0 0 0 0", a_ready, a_esp, a_nv, a_fs, a_busy);
    end
    checks++;
    if ({b_ready, b_esp, b_nv, b_fs, b_busy} !== {1'b1, 4'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b got rdy=%b esp=%h nv=%b fs=%b busy=%b exp 1 0 0 0 0", b_ready, b_esp, b_nv, b_fs, b_busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hAABBCCDD;
    a_word = w; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({a_esp, a_nv, a_fs, a_ready, a_busy} !== {w[31-4*i -: 4], 1'b1, (i == 0), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_nib%0d got esp=%h nv=%b fs=%b rdy=%b busy=%b exp esp=%h nv=1 fs=%b rdy=0 busy=1",
                 i, a_esp, a_nv, a_fs, a_ready, a_busy, w[31-4*i -: 4], (i == 0));
      end
      tick();
    end
    checks++;
    if ({a_ready, a_nv, a_busy, a_esp} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL single_ready got rdy=%b nv=%b busy=%b esp=%h exp 1 0 0 0", a_ready, a_nv, a_busy, a_esp);
    end
  endtask

  task automatic test_hold();
    logic [31:0] w;
    w = 32'h12345678;
    b_word = w; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    b_word = 32'hFFFFFFFF;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if ({b_esp, b_nv, b_fs, b_ready} !== {w[31-4*(c/3) -: 4], 1'b1, (c < 3), 1'b0}) begin
        errors++;
        $display("FAIL hold_cyc%0d got esp=%h nv=%b fs=%b rdy=%b exp esp=%h nv=1 fs=%b rdy=0",
                 c, b_esp, b_nv, b_fs, b_ready, w[31-4*(c/3) -: 4], (c < 3));
      end
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({b_nv, b_fs, b_ready, b_busy, b_esp} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'h0}) begin
        errors++;
        $display("FAIL hold_gap%0d got nv=%b fs=%b rdy=%b busy=%b esp=%h exp 0 0 0 1 0", g, b_nv, b_fs, b_ready, b_busy, b_esp);
      end
      tick();
    end
    checks++;
    if ({b_ready, b_busy} !== 2'b10) begin
      errors++;
      $display("FAIL hold_ready got rdy=%b busy=%b exp 1 0", b_ready, b_busy);
    end
  endtask

  task automatic test_abort_gap();
    b_word = 32'h0F0F0F0F; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    checks++;
    if ({b_busy, b_ready, b_nv} !== 3'b100) begin
      errors++;
      $display("FAIL abort_gap_pre got busy=%b rdy=%b nv=%b exp 1 0 0", b_busy, b_ready, b_nv);
    end
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    checks++;
    if ({b_ready, b_busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_gap_post got rdy=%b busy=%b exp 1 0", b_ready, b_busy);
    end
  endtask

  task automatic test_back_to_back();
    int since;
    a_word = 32'h11111111; a_valid = 1'b1;
    tick();
    a_word = 32'h22222222;
    since = 1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({a_esp, a_nv, a_fs} !== {4'h1, 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL b2b_w1_nib%0d got esp=%h nv=%b fs=%b exp esp=1 nv=1 fs=%b", i, a_esp, a_nv, a_fs, (i == 0));
      end
      if (!a_ready) since++;
      tick();
    end
    checks++;
    if ({a_ready, since} !== {1'b1, 32'sd9}) begin
      errors++;
      $display("FAIL b2b_accept_gap got rdy=%b cycles=%0d exp rdy=1 cycles=9", a_ready, since);
    end
    tick();
    a_word = 32'h33333333;
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({a_esp, a_nv, a_fs} !== {4'h2, 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL b2b_w2_nib%0d got esp=%h nv=%b fs=%b exp esp=2 nv=1 fs=%b", i, a_esp, a_nv, a_fs, (i == 0));
      end
      tick();
    end
    checks++;
    if ({a_ready, a_nv} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_end got rdy=%b nv=%b exp 1 0", a_ready, a_nv);
    end
  endtask

  task automatic test_abort();
    logic [31:0] w;
    a_word = 32'hDEADBEEF; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({a_esp, a_nv} !== {4'hD, 1'b1}) begin
      errors++;
      $display("FAIL abort_nib3 got esp=%h nv=%b exp esp=d nv=1", a_esp, a_nv);
    end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    checks++;
    if ({a_esp, a_nv, a_ready, a_busy} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_post got esp=%h nv=%b rdy=%b busy=%b exp 0 0 1 0", a_esp, a_nv, a_ready, a_busy);
    end
    a_word = 32'h55555555; a_valid = 1'b1; a_abort = 1'b1;
    tick();
    a_abort = 1'b0; a_valid = 1'b0;
    checks++;
    if ({a_ready, a_busy, a_nv} !== 3'b100) begin
      errors++;
      $display("FAIL abort_wins got rdy=%b busy=%b nv=%b exp 1 0 0", a_ready, a_busy, a_nv);
    end
    w = 32'h9ABCDEF0;
    a_word = w; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({a_esp, a_nv, a_fs} !== {w[31-4*i -: 4], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL abort_next_nib%0d got esp=%h nv=%b fs=%b exp esp=%h fs=%b", i, a_esp, a_nv, a_fs, w[31-4*i -: 4], (i == 0));
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    a_word = 32'h87654321; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({a_esp, a_nv} !== {4'h3, 1'b1}) begin
      errors++;
      $display("FAIL areset_nib5 got esp=%h nv=%b exp esp=3 nv=1", a_esp, a_nv);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_esp, a_nv, a_fs, a_ready, a_busy} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_clear got esp=%h nv=%b fs=%b rdy=%b busy=%b exp 0 0 0 1 0", a_esp, a_nv, a_fs, a_ready, a_busy);
    end
    tick();
    rst = 1'b0;
    tick();
    w = 32'hCAFEF00D;
    a_word = w; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({a_esp, a_nv, a_fs} !== {w[31-4*i -: 4], 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL areset_next_nib%0d got esp=%h nv=%b fs=%b exp esp=%h fs=%b", i, a_esp, a_nv, a_fs, w[31-4*i -: 4], (i == 0));
      end
      tick();
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_end got rdy=%b exp 1", a_ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_hold();
    test_abort_gap();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t07_esp_tx.md
# t07_esp_tx

Nibble-bus transmitter; the sending end of the 4-bit parallel ESP link that `t07_top` receives on `ESP_in`. It accepts 32-bit words through a valid/ready handshake and drives each word out as 8 nibbles, MSB nibble first, each nibble held for a programmable number of clocks. It serves two roles: the on-chip return path toward the ESP, and the synthesizable stimulus source for the ESP receive path in top-level benches.

## Interface
- `HOLD_CYCLES`, default 1: clocks each nibble is held on `ESP_out`. Legal range ≥1.
- `GAP_CYCLES`, default 0: idle clocks inserted after the last nibble of a word. Legal range ≥0.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `word_i` input, 32 bits: word to transmit.
- `wordValid_i` input, 1 bit: `word_i` is valid.
- `wordReady_o` output, 1 bit: the transmitter can accept a word.
- `abort_i` input, 1 bit: cancels the current word synchronously.
- `ESP_out` output, 4 bits: nibble bus.
- `nibbleValid_o` output, 1 bit: `ESP_out` carries a data nibble.
- `frameStart_o` output, 1 bit: high for every cycle of nibble 0 (bits [31:28]).
- `busy_o` output, 1 bit: high in SEND or GAP.

## Operation
- The FSM has three states: IDLE, SEND, GAP.
- **IDLE**
  - `wordReady_o`=1.
  - If `wordValid_i`=1 and `abort_i`=0 on a rising edge:
    - latch `word_i` into the shift register;
    - clear `nibCnt` (3 bits) and `holdCnt`;
    - go to SEND.
- **SEND**
  - `ESP_out` = shift[31:28]; `nibbleValid_o`=1; `frameStart_o` = (`nibCnt`==0).
  - `holdCnt` counts 0..HOLD_CYCLES-1. On the terminal count, shift left by 4, increment `nibCnt`, and clear `holdCnt`.
  - On the terminal count with `nibCnt`==7:
    - go to GAP if GAP_CYCLES>0;
    - otherwise go to IDLE.
- **GAP**
  - Count GAP_CYCLES clocks, then go to IDLE.
- In every state other than SEND, `ESP_out`=4'h0, `nibbleValid_o`=0 and `frameStart_o`=0.
- `word_i` is sampled only at acceptance. Changes to it while `busy_o`=1 have no effect.
- `wordValid_i` while not ready:
  - no capture and no data loss;
  - the source holds the word until it sees `wordReady_o`.
- `abort_i`=1 in SEND or GAP: on the next edge go to IDLE and clear the shift register and counters. No partial nibble is completed.
- `abort_i` together with `wordValid_i` in IDLE: abort wins and the word is not accepted.
- `rst` asserted at any time, including mid-word: all state clears immediately, regardless of the clock.

## Timing
- Reset values: `wordReady_o`=1, `ESP_out`=0, `nibbleValid_o`=0, `frameStart_o`=0, `busy_o`=0, state=IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Latency: the word is accepted on edge N. The first nibble appears after edge N, in cycle N+1.
- Word duration: 8·HOLD_CYCLES cycles of `nibbleValid_o`, then GAP_CYCLES idle cycles, then one IDLE cycle with ready.
- Maximum throughput: one word per 8·HOLD_CYCLES + GAP_CYCLES + 1 clocks.
- `wordReady_o` is low from the cycle after acceptance until the cycle after the last SEND or GAP clock.
- Abort takes effect in exactly one cycle. `wordReady_o` is 1 in the cycle after the abort edge.

## Structure
- Shared package `t07_esp_pkg`:
  - `esp_tx_state_t` enum {IDLE, SEND, GAP};
  - localparams `ESP_NIBBLES`=8 and `ESP_WORD_W`=32;
  - the receiver uses the same constants.
- One sub-module, `t07_esp_hold_timer`: a loadable down-counter with a terminal-count pulse.
  - It is instantiated twice, once for nibble hold and once for the gap.
  - Width is `$clog2` of the maximum of the parameter and 2.
- Everything else lives in one module: FSM, shift register, and `nibCnt`.

## Test plan
- **Reset:** assert `rst` with no clock edge.
  - All outputs reach their reset values immediately.
  - `wordReady_o`=1.
- **Single word, HOLD=1, GAP=0:** send 0xAABBCCDD.
  - `ESP_out` = A,A,B,B,C,C,D,D on cycles N+1..N+8.
  - `frameStart_o` is high only on N+1.
  - `wordReady_o` is high again on N+9.
- **Hold timing, HOLD=3, GAP=2:** send 0x12345678.
  - Each nibble lasts 3 cycles, 24 cycles in total.
  - `frameStart_o` is high for 3 cycles.
  - There are 2 idle cycles, then ready.
- **Back-to-back, HOLD=1:** hold `wordValid_i` high with 0x11111111 then 0x22222222.
  - The second word is accepted exactly 9 cycles after the first.
  - Nothing is dropped or duplicated.
  - Changing `word_i` mid-transmission does not alter the output.
- **Abort:** pulse `abort_i` during nibble 3 of 0xDEADBEEF.
  - `ESP_out`=0 and `nibbleValid_o`=0 on the next cycle; ready is 1.
  - The next word starts cleanly from nibble 0.
  - Abort together with valid in IDLE does not accept the word.
- **Async reset mid-word:** assert `rst` between clock edges during nibble 5.
  - Outputs clear before the next edge.
  - After release, 0xCAFEF00D transmits correctly.
